// File: rtl/fdiv_pkg.sv
// fdiv_pkg: shared types and constants for the single-precision divide controller.
package fdiv_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_DIV, RESP} state_t;
  localparam logic [31:0] CANON_NAN = 32'h7FC00000;
  localparam int BIAS = 127;
  localparam int EXP_W = 8;
  localparam int FRAC_W = 23;
  localparam int FLAG_NV = 4;
  localparam int FLAG_DZ = 3;
  localparam int FLAG_OF = 2;
  localparam int FLAG_UF = 1;
  localparam int FLAG_NX = 0;
  typedef struct packed {
    logic zero;
    logic denorm;
    logic inf;
    logic qnan;
    logic snan;
  } fp_class_t;
endpackage

// File: rtl/fp_operand_classify.sv
// fp_operand_classify: decodes one single-precision operand into its IEEE class.
module fp_operand_classify
  import fdiv_pkg::*;
(
  input  logic [31:0] op_i,
  output fp_class_t   cls_o
);
  logic [EXP_W-1:0] e;
  logic [FRAC_W-1:0] f;
  assign e = op_i[FRAC_W +: EXP_W];
  assign f = op_i[FRAC_W-1:0];
  always_comb begin
    cls_o.zero   = (e == '0) && (f == '0);
    cls_o.denorm = (e == '0) && (f != '0);
    cls_o.inf    = (&e) && (f == '0);
    cls_o.qnan   = (&e) && f[FRAC_W-1];
    cls_o.snan   = (&e) && (f != '0) && !f[FRAC_W-1];
  end
endmodule

// File: rtl/fdiv_controller.sv
// fdiv_controller: FP32 divide sequencer; resolves special cases locally and
// otherwise waits on a free-running significand divider, truncating the result.
module fdiv_controller
  import fdiv_pkg::*;
#(
  parameter int MANTISSA_WIDTH  = 24,
  parameter int DIV_PULSES_SKIP = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic [31:0]               req_a,
  input  logic [31:0]               req_b,
  input  logic                      flush,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [31:0]               rsp_result,
  output logic [4:0]                rsp_flags,
  output logic [MANTISSA_WIDTH-1:0] div_dividend,
  output logic [MANTISSA_WIDTH-1:0] div_divisor,
  input  logic [MANTISSA_WIDTH:0]   div_quotient,
  input  logic                      div_valid
);
  localparam int M = MANTISSA_WIDTH;
  localparam int CW = $clog2(DIV_PULSES_SKIP + 1) + 1;
  state_t state_q, state_d;
  logic [31:0] a_q, a_d, b_q, b_d, res_q, res_d;
  logic [4:0] flg_q, flg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  fp_class_t ca, cb;
  logic za, zb, nan_a, nan_b, inv, sp_hit, s_req, s_op;
  logic [31:0] sp_res, nr_res;
  logic [4:0] sp_flg, nr_flg;
  logic signed [9:0] e_raw, e_n;
  logic [FRAC_W-1:0] frac;
  fp_operand_classify u_cls_a (.op_i(req_a), .cls_o(ca));
  fp_operand_classify u_cls_b (.op_i(req_b), .cls_o(cb));
  // Denormals are flushed, so they classify as zero for every special case.
  always_comb begin
    za     = ca.zero | ca.denorm;
    zb     = cb.zero | cb.denorm;
    nan_a  = ca.qnan | ca.snan;
    nan_b  = cb.qnan | cb.snan;
    inv    = (za & zb) | (ca.inf & cb.inf);
    s_req  = req_a[31] ^ req_b[31];
    sp_hit = nan_a | nan_b | za | zb | ca.inf | cb.inf;
    sp_res = (nan_a | nan_b | inv) ? CANON_NAN :
             (ca.inf | zb)         ? {s_req, 8'hFF, 23'd0} : {s_req, 31'd0};
    sp_flg = (inv | ca.snan | cb.snan)     ? 5'(1 << FLAG_NV) :
             (zb & !nan_a & !ca.inf)       ? 5'(1 << FLAG_DZ) : 5'd0;
  end
  always_comb begin
    s_op   = a_q[31] ^ b_q[31];
    e_raw  = $signed({2'b00, a_q[30:23]}) - $signed({2'b00, b_q[30:23]}) + 10'(BIAS);
    e_n    = div_quotient[M] ? e_raw : e_raw - 10'sd1;
    frac   = div_quotient[M] ? div_quotient[M-1 -: FRAC_W] : div_quotient[M-2 -: FRAC_W];
    nr_res = (e_n >= 10'sd255) ? {s_op, 8'hFF, 23'd0} :
             (e_n <= 10'sd0)   ? {s_op, 31'd0} : {s_op, e_n[7:0], frac};
    nr_flg = (e_n >= 10'sd255) ? 5'((1 << FLAG_OF) | (1 << FLAG_NX)) :
             (e_n <= 10'sd0)   ? 5'((1 << FLAG_UF) | (1 << FLAG_NX)) : 5'd0;
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    flg_d   = flg_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: if (req_valid) begin
          a_d     = req_a;
          b_d     = req_b;
          res_d   = sp_res;
          flg_d   = sp_flg;
          cnt_d   = '0;
          state_d = sp_hit ? RESP : WAIT_DIV;
        end
        WAIT_DIV: if (div_valid) begin
          if (cnt_q == CW'(DIV_PULSES_SKIP)) begin
            res_d   = nr_res;
            flg_d   = nr_flg;
            cnt_d   = '0;
            state_d = RESP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        RESP: state_d = rsp_ready ? IDLE : RESP;
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      flg_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      flg_q   <= flg_d;
      cnt_q   <= cnt_d;
    end
  end
  assign req_ready    = state_q == IDLE;
  assign rsp_valid    = state_q == RESP;
  assign rsp_result   = rsp_valid ? res_q : '0;
  assign rsp_flags    = rsp_valid ? flg_q : '0;
  assign div_dividend = (state_q == WAIT_DIV) ? M'({1'b1, a_q[FRAC_W-1:0]}) : '0;
  assign div_divisor  = (state_q == WAIT_DIV) ? M'({1'b1, b_q[FRAC_W-1:0]}) : '0;
endmodule

// File: tb/tb_fdiv_controller.sv
// tb_fdiv_controller: scoreboard bench with a free-running 25-cycle divider model.
module tb_fdiv_controller;
  logic clk = 0, rst_n, req_valid, req_ready, flush, rsp_valid, rsp_ready, div_valid;
  logic [31:0] req_a, req_b, rsp_result;
  logic [4:0] rsp_flags;
  logic [23:0] div_dividend, div_divisor;
  logic [24:0] div_quotient;
  logic [4:0] dcnt = 0;
  logic [47:0] num, den;
  logic [36:0] sb[$];
  int n_vec = 0, n_err = 0;
  fdiv_controller dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .flush(flush), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_result(rsp_result), .rsp_flags(rsp_flags),
    .div_dividend(div_dividend), .div_divisor(div_divisor),
    .div_quotient(div_quotient), .div_valid(div_valid)
  );
  always #5 clk = ~clk;
  always @(posedge clk) dcnt <= (dcnt == 5'd24) ? 5'd0 : dcnt + 5'd1;
  assign div_valid = dcnt == 5'd24;
  assign num = {div_dividend, 24'd0};
  assign den = {24'd0, div_divisor};
  assign div_quotient = (div_divisor == 0) ? 25'd0 : 25'(num / den);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [36:0] model(input logic [31:0] a, input logic [31:0] b);
    logic s, na, nb, sn, za, zb, ia, ib;
    logic [63:0] q;
    int e;
    logic [22:0] fr;
    s  = a[31] ^ b[31];
    na = a[30:23] == 8'hFF && a[22:0] != 0;
    nb = b[30:23] == 8'hFF && b[22:0] != 0;
    sn = (na && !a[22]) || (nb && !b[22]);
    za = a[30:23] == 0;
    zb = b[30:23] == 0;
    ia = a[30:23] == 8'hFF && a[22:0] == 0;
    ib = b[30:23] == 8'hFF && b[22:0] == 0;
    if (na || nb) return {sn ? 5'b10000 : 5'b00000, 32'h7FC00000};
    if ((za && zb) || (ia && ib)) return {5'b10000, 32'h7FC00000};
    if (ia) return {5'b0, s, 8'hFF, 23'd0};
    if (ib || za) return {5'b0, s, 31'd0};
    if (zb) return {5'b01000, s, 8'hFF, 23'd0};
    q = ({40'd0, 1'b1, a[22:0]} << 24) / {40'd0, 1'b1, b[22:0]};
    e = int'(a[30:23]) - int'(b[30:23]) + 127;
    if (q[24]) fr = q[23:1];
    else begin
      fr = q[22:0];
      e--;
    end
    if (e >= 255) return {5'b00101, s, 8'hFF, 23'd0};
    if (e <= 0) return {5'b00011, s, 31'd0};
    return {5'b0, s, 8'(e), fr};
  endfunction
  task automatic send(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 1);
    req_a = a;
    req_b = b;
    req_valid = 1;
    @(posedge clk);
    sb.push_back(model(a, b));
    #1 req_valid = 0;
  endtask
  task automatic run(input logic [31:0] a, input logic [31:0] b, input int maxlat, input int stall);
    int lat;
    logic [36:0] ex;
    logic [31:0] r;
    logic [4:0] f;
    send(a, b);
    lat = 1;
    @(negedge clk);
    while (!rsp_valid && lat < maxlat) begin
      @(negedge clk);
      lat++;
    end
    chk($sformatf("rsp_valid_lat%0d", maxlat), 32'(rsp_valid), 1);
    ex = sb.pop_front();
    if (!rsp_valid) return;
    r = rsp_result;
    f = rsp_flags;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      chk("stall_result", rsp_result, r);
      chk("stall_flags", 32'(rsp_flags), 32'(f));
      chk("stall_ready", 32'(req_ready), 0);
    end
    chk($sformatf("result_%h_%h", a, b), rsp_result, ex[31:0]);
    chk($sformatf("flags_%h_%h", a, b), 32'(rsp_flags), 32'(ex[36:32]));
    rsp_ready = 1;
    @(negedge clk);
    rsp_ready = 0;
    chk("idle_after_hs", 32'(req_ready), 1);
    chk("rsp_cleared", rsp_result, 0);
  endtask
  task automatic quiet(input string tag);
    logic seen = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      seen |= rsp_valid;
    end
    chk(tag, 32'(seen), 0);
  endtask
  initial begin
    rst_n = 0; req_valid = 0; req_a = 0; req_b = 0; flush = 0; rsp_ready = 0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 1);
    chk("rst_valid", 32'(rsp_valid), 0);
    chk("rst_result", rsp_result, 0);
    chk("rst_flags", 32'(rsp_flags), 0);
    chk("rst_dividend", 32'(div_dividend), 0);
    chk("rst_divisor", 32'(div_divisor), 0);
    rst_n = 1;
    run(32'h40C00000, 32'h40000000, 51, 0);
    run(32'h3F800000, 32'h00000000, 1, 30);
    run(32'h00000000, 32'h00000000, 1, 0);
    run(32'h7F800001, 32'h3F800000, 1, 0);
    run(32'h7FC00001, 32'h3F800000, 1, 0);
    run(32'h7F800000, 32'hFF800000, 1, 0);
    run(32'hFF800000, 32'h40000000, 1, 0);
    run(32'h40000000, 32'hFF800000, 1, 0);
    run(32'h00400000, 32'h3F800000, 1, 0);
    run(32'h3F800000, 32'h80400000, 1, 0);
    run(32'h7F000000, 32'h3E800000, 51, 0);
    run(32'h00800000, 32'h4B000000, 51, 0);
    run(32'hC0C00000, 32'h40000000, 51, 0);
    run(32'h3F800000, 32'h40400000, 51, 5);
    send(32'h3F800000, 32'h40000000);
    void'(sb.pop_front());
    repeat (10) @(negedge clk);
    chk("wait_dividend", 32'(div_dividend), 32'h800000);
    chk("wait_divisor", 32'(div_divisor), 32'h800000);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("flush_ready", 32'(req_ready), 1);
    chk("flush_valid", 32'(rsp_valid), 0);
    chk("flush_dividend", 32'(div_dividend), 0);
    quiet("flush_no_rsp");
    run(32'h3F800000, 32'h40800000, 51, 0);
    send(32'h40C00000, 32'h40000000);
    void'(sb.pop_front());
    repeat (5) @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("midrst_ready", 32'(req_ready), 1);
    chk("midrst_divisor", 32'(div_divisor), 0);
    rst_n = 1;
    quiet("midrst_no_rsp");
    for (int i = 0; i < 10; i++)
      run({1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)},
          {1'($urandom), 8'($urandom_range(64, 190)), 23'($urandom)}, 51, 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/fdiv_controller.md
FDIV_CONTROLLER -- requirements
Module: fdiv_controller

Interface
REQ-001 Parameter MANTISSA_WIDTH, default 24, is the significand width including the hidden bit and the width of the divider operand ports.
REQ-002 Parameter DIV_PULSES_SKIP, default 1, is the number of div_valid pulses discarded after launch before a quotient is accepted.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present.
REQ-006 req_ready  output  1  controller can accept a request.
REQ-007 req_a  input  32  IEEE-754 single-precision dividend.
REQ-008 req_b  input  32  IEEE-754 single-precision divisor.
REQ-009 flush  input  1  abort the in-flight operation.
REQ-010 rsp_valid  output  1  result present.
REQ-011 rsp_ready  input  1  consumer accepts the result.
REQ-012 rsp_result  output  32  quotient.
REQ-013 rsp_flags  output  5  {NV,DZ,OF,UF,NX}.
REQ-014 div_dividend  output  MANTISSA_WIDTH  significand to the divider, {1,frac_a}.
REQ-015 div_divisor  output  MANTISSA_WIDTH  significand to the divider, {1,frac_b}.
REQ-016 div_quotient  input  MANTISSA_WIDTH+1  divider quotient.
REQ-017 div_valid  input  1  one-cycle pulse from the free-running divider, once per 25 cycles.

Function
REQ-018 States SHALL be IDLE, WAIT_DIV and RESP; req_ready SHALL be 1 only in IDLE.
REQ-019 A request SHALL be accepted when req_valid&&req_ready; the operands and the classification result SHALL be registered.
REQ-020 Special cases SHALL go IDLE->RESP with rsp_valid high on the cycle after acceptance, and SHALL not wait on the divider.
REQ-021 Special-case results:
- NaN input, 0/0, inf/inf: 0x7FC00000; NV is set for 0/0, inf/inf and any signalling NaN.
- finite nonzero/0: signed inf, DZ.
- inf/finite: signed inf.
- finite/inf and 0/nonzero: signed zero.
REQ-022 Denormal inputs SHALL be treated as signed zero (flush-to-zero).
REQ-023 Normal operands SHALL go IDLE->WAIT_DIV.
- div_dividend/div_divisor are held constant from the cycle after acceptance until leaving WAIT_DIV.
- Outside WAIT_DIV both are driven to 0.
REQ-024 In WAIT_DIV the controller SHALL count div_valid pulses and capture div_quotient on pulse number DIV_PULSES_SKIP+1, then go to RESP; worst-case latency is 2*25+1 cycles.
REQ-025 Result sign = sign_a^sign_b; exponent e = ea-eb+127 (10-bit signed arithmetic).
REQ-026 Normalisation: if div_quotient[24]=1, fraction = div_quotient[23:1]; otherwise fraction = div_quotient[22:0] and e = e-1.
REQ-027 Rounding SHALL be round-toward-zero (truncation).
REQ-028 e>=255 SHALL give signed inf with OF and NX; e<=0 SHALL give signed zero with UF and NX.
REQ-029 In RESP, rsp_valid=1 and rsp_result/rsp_flags SHALL stay stable until rsp_valid&&rsp_ready, then the state SHALL return to IDLE; there is no IDLE bypass on the same cycle.
REQ-030 flush SHALL force IDLE on the next edge from any state and discard pending results and pulse counts; flush has priority over acceptance and rsp handshake on the same cycle.
REQ-031 Outside RESP, rsp_result and rsp_flags SHALL be 0.

Reset
REQ-032 While rst_n=0: state=IDLE, pulse count=0, req_ready=1, rsp_valid=0, rsp_result=0, rsp_flags=0, div_dividend=0, div_divisor=0.
REQ-033 Reset mid-operation SHALL abandon the operation with no response; the divider's later pulses SHALL be ignored.

Structure
REQ-034 Package fdiv_pkg SHALL hold the state enum, CANON_NAN=32'h7FC00000, BIAS=127, EXP_W=8, FRAC_W=23 and the flag bit indices.
REQ-035 One combinational sub-module, fp_operand_classify, SHALL decode zero/denormal/inf/qNaN/sNaN per operand; it is instantiated twice.

Verification
REQ-036 0x40C00000/0x40000000 (6/2) -> rsp_result 0x40400000, flags 0, rsp_valid within 51 cycles of acceptance.
REQ-037 0x3F800000/0x00000000 -> 0x7F800000, DZ only, rsp_valid the cycle after acceptance, div_valid pulses ignored.
REQ-038 0x00000000/0x00000000 -> 0x7FC00000, NV; 0x7F800001/0x3F800000 -> 0x7FC00000, NV.
REQ-039 0x7F000000/0x3E800000 -> 0x7F800000 with OF and NX; 0x00800000/0x4B000000 -> 0x00000000 with UF and NX.
REQ-040 flush 10 cycles into WAIT_DIV -> no rsp_valid, req_ready=1 next cycle; then 0x3F800000/0x40800000 -> 0x3E800000.
REQ-041 rsp_ready low for 5 cycles in RESP -> rsp_result/rsp_flags stable and req_ready=0 throughout; IDLE one cycle after the handshake.
